// File: rtl/fetch_unit.sv
// Program counter and byte fetch sequencer feeding the decoder through a valid/ready handshake.
// Assembles one- or two-byte instructions (bit 7 of the opcode selects two-byte) and handles jumps.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] iAddr,
    output logic       FETCH,
    input  logic [7:0] instr,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [7:0] ir_op,
    output logic [7:0] ir_operand,
    output logic       ir_two_byte,
    output logic [7:0] ir_pc,
    input  logic       jump_en,
    input  logic [7:0] jump_addr
);

    typedef enum logic [2:0] {
        StF1   = 3'd0,
        StW1   = 3'd1,
        StF2   = 3'd2,
        StW2   = 3'd3,
        StHold = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_op_q, ir_op_d;
    logic [7:0] ir_operand_q, ir_operand_d;
    logic [7:0] ir_pc_q, ir_pc_d;
    logic       ir_two_byte_q, ir_two_byte_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StF1;
            pc_q          <= RESET_PC;
            ir_op_q       <= 8'h00;
            ir_operand_q  <= 8'h00;
            ir_pc_q       <= 8'h00;
            ir_two_byte_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_op_q       <= ir_op_d;
            ir_operand_q  <= ir_operand_d;
            ir_pc_q       <= ir_pc_d;
            ir_two_byte_q <= ir_two_byte_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_op_d       = ir_op_q;
        ir_operand_d  = ir_operand_q;
        ir_pc_d       = ir_pc_q;
        ir_two_byte_d = ir_two_byte_q;

        // A jump discards whatever is captured or in flight; the ir_* registers keep their
        // stale contents, which are harmless because ir_valid is low until the next HOLD.
        if (jump_en) begin
            pc_d    = jump_addr;
            state_d = StF1;
        end else begin
            unique case (state_q)
                StF1: begin
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + 8'd1;
                    state_d = StW1;
                end
                StW1: begin
                    ir_op_d = instr;
                    if (instr[7]) begin
                        ir_two_byte_d = 1'b1;
                        state_d       = StF2;
                    end else begin
                        ir_operand_d  = 8'h00;
                        ir_two_byte_d = 1'b0;
                        state_d       = StHold;
                    end
                end
                StF2: begin
                    pc_d    = pc_q + 8'd1;
                    state_d = StW2;
                end
                StW2: begin
                    ir_operand_d = instr;
                    state_d      = StHold;
                end
                StHold: begin
                    if (ir_ready) begin
                        state_d = StF1;
                    end
                end
                default: begin
                    state_d = StF1;
                end
            endcase
        end
    end

    assign iAddr       = pc_q;
    assign FETCH       = (state_q == StF1) || (state_q == StF2);
    assign ir_valid    = (state_q == StHold);
    assign ir_op       = ir_op_q;
    assign ir_operand  = ir_operand_q;
    assign ir_pc       = ir_pc_q;
    assign ir_two_byte = ir_two_byte_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random run
// scored against an instruction-stream model of the program memory.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] iAddr;
    logic       FETCH;
    logic [7:0] instr;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_op;
    logic [7:0] ir_operand;
    logic       ir_two_byte;
    logic [7:0] ir_pc;
    logic       jump_en;
    logic [7:0] jump_addr;

    logic [7:0] mem [256];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    fetch_unit #(
        .RESET_PC(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iAddr      (iAddr),
        .FETCH      (FETCH),
        .instr      (instr),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_op      (ir_op),
        .ir_operand (ir_operand),
        .ir_two_byte(ir_two_byte),
        .ir_pc      (ir_pc),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after FETCH is sampled.
    always @(posedge clk) begin
        if (FETCH) instr <= mem[iAddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        jump_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] mpc;
    logic [7:0] e_op, e_operand;
    logic       e_two;
    logic [7:0] s_op, s_operand, s_pc;
    logic       s_two;
    logic       held_prev;
    logic       rdy, jmp;
    logic [7:0] jaddr;
    int         idle;
    int         hs;

    initial begin
        rst       = 1'b1;
        ir_ready  = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 8'h00;
        instr     = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // One-byte stream with ready held high.
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        ir_ready = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_valid", ir_valid, 0);
        chk("rst_op", ir_op, 8'h00);
        chk("rst_operand", ir_operand, 8'h00);
        chk("rst_pc", ir_pc, 8'h00);
        chk("rst_two", ir_two_byte, 0);
        chk("rst_fetch", FETCH, 1);
        chk("rst_iaddr", iAddr, 8'h00);
        rst = 1'b0;
        tick();
        chk("w1_fetch", FETCH, 0);
        chk("w1_valid", ir_valid, 0);
        tick();
        chk("i0_valid", ir_valid, 1);
        chk("i0_op", ir_op, 8'h11);
        chk("i0_pc", ir_pc, 8'h00);
        chk("i0_operand", ir_operand, 8'h00);
        chk("i0_two", ir_two_byte, 0);
        tick();
        chk("i1_fetch", FETCH, 1);
        chk("i1_iaddr", iAddr, 8'h01);
        tick();
        tick();
        chk("i1_valid", ir_valid, 1);
        chk("i1_op", ir_op, 8'h22);
        chk("i1_pc", ir_pc, 8'h01);
        ir_ready = 1'b0;

        // Two-byte instruction, then backpressure.
        mem[0] = 8'h85;
        mem[1] = 8'h3C;
        mem[2] = 8'h01;
        do_reset();
        chk("tb_f1_iaddr", iAddr, 8'h00);
        tick();
        chk("tb_w1_fetch", FETCH, 0);
        tick();
        chk("tb_f2_fetch", FETCH, 1);
        chk("tb_f2_iaddr", iAddr, 8'h01);
        tick();
        chk("tb_w2_valid", ir_valid, 0);
        tick();
        chk("tb_valid", ir_valid, 1);
        chk("tb_op", ir_op, 8'h85);
        chk("tb_operand", ir_operand, 8'h3C);
        chk("tb_two", ir_two_byte, 1);
        chk("tb_pc", ir_pc, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", ir_valid, 1);
            chk("bp_fetch", FETCH, 0);
            chk("bp_op", ir_op, 8'h85);
            chk("bp_operand", ir_operand, 8'h3C);
            chk("bp_pc", ir_pc, 8'h00);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("rel_valid", ir_valid, 0);
        chk("rel_fetch", FETCH, 1);
        chk("rel_iaddr", iAddr, 8'h02);
        tick();
        tick();
        chk("rel_next_valid", ir_valid, 1);
        chk("rel_next_op", ir_op, 8'h01);
        chk("rel_next_pc", ir_pc, 8'h02);
        tick();
        chk("one_hs_valid", ir_valid, 1);
        chk("one_hs_pc", ir_pc, 8'h02);

        // Jump while the operand byte is in flight.
        mem[3]    = 8'hA0;
        mem[4]    = 8'h55;
        mem[8'h40] = 8'h12;
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("j_f1_iaddr", iAddr, 8'h03);
        tick();
        tick();
        chk("j_f2_iaddr", iAddr, 8'h04);
        tick();
        chk("j_w2_fetch", FETCH, 0);
        jump_en   = 1'b1;
        jump_addr = 8'h40;
        tick();
        jump_en = 1'b0;
        chk("j_fetch", FETCH, 1);
        chk("j_iaddr", iAddr, 8'h40);
        chk("j_no_present", ir_valid, 0);
        tick();
        chk("j_w1_valid", ir_valid, 0);
        tick();
        chk("j_valid", ir_valid, 1);
        chk("j_op", ir_op, 8'h12);
        chk("j_pc", ir_pc, 8'h40);
        chk("j_two", ir_two_byte, 0);

        // Jump from HOLD to 0xFF: operand wraps to address 0.
        mem[8'hFF] = 8'h90;
        mem[0]     = 8'h07;
        mem[1]     = 8'h33;
        jump_en   = 1'b1;
        jump_addr = 8'hFF;
        tick();
        jump_en = 1'b0;
        chk("w_iaddr", iAddr, 8'hFF);
        chk("w_fetch", FETCH, 1);
        tick();
        tick();
        chk("w_f2_iaddr", iAddr, 8'h00);
        tick();
        tick();
        chk("w_valid", ir_valid, 1);
        chk("w_op", ir_op, 8'h90);
        chk("w_operand", ir_operand, 8'h07);
        chk("w_pc", ir_pc, 8'hFF);
        chk("w_two", ir_two_byte, 1);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("w_next_iaddr", iAddr, 8'h01);
        chk("w_next_fetch", FETCH, 1);
        tick();
        tick();
        chk("w_next_op", ir_op, 8'h33);

        // Reset in HOLD beats a simultaneous jump.
        rst       = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 8'h40;
        tick();
        rst     = 1'b0;
        jump_en = 1'b0;
        chk("rh_valid", ir_valid, 0);
        chk("rh_iaddr", iAddr, 8'h00);
        chk("rh_fetch", FETCH, 1);
        chk("rh_op", ir_op, 8'h00);
        chk("rh_pc", ir_pc, 8'h00);

        // Random run against the instruction-stream model.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        mpc       = 8'h00;
        held_prev = 1'b0;
        idle      = 0;
        hs        = 0;
        s_op = 8'h00; s_operand = 8'h00; s_pc = 8'h00; s_two = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("r_fetch_in_hold", FETCH & ir_valid, 0);
            if (held_prev) begin
                chk("r_hold_valid", ir_valid, 1);
                chk("r_hold_op", ir_op, s_op);
                chk("r_hold_operand", ir_operand, s_operand);
                chk("r_hold_pc", ir_pc, s_pc);
                chk("r_hold_two", ir_two_byte, s_two);
            end
            if (!ir_valid) idle++;
            else idle = 0;
            if (idle > 4) chk("r_stall_bound", idle, 4);

            rdy   = 1'($urandom_range(0, 1));
            jmp   = ($urandom_range(0, 15) == 0);
            jaddr = 8'($urandom);

            if (ir_valid && rdy && !jmp) begin
                e_op      = mem[mpc];
                e_two     = e_op[7];
                e_operand = e_two ? mem[8'(mpc + 8'd1)] : 8'h00;
                chk("r_op", ir_op, e_op);
                chk("r_operand", ir_operand, e_operand);
                chk("r_two", ir_two_byte, e_two);
                chk("r_pc", ir_pc, mpc);
                mpc = e_two ? 8'(mpc + 8'd2) : 8'(mpc + 8'd1);
                hs++;
            end
            if (jmp) begin
                mpc  = jaddr;
                idle = 0;
            end
            held_prev = ir_valid && !rdy && !jmp;
            s_op      = ir_op;
            s_operand = ir_operand;
            s_pc      = ir_pc;
            s_two     = ir_two_byte;

            ir_ready  = rdy;
            jump_en   = jmp;
            jump_addr = jaddr;
            tick();
        end
        ir_ready = 1'b0;
        jump_en  = 1'b0;
        chk("r_handshakes", (hs > 100), 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
